// File: rtl/cheshire_commit_watchdog.sv
// Commit-stage hang watchdog: arms on the first commit, counts enabled cycles without
// commit-PC progress, then requests a debug halt for a grace period and flags finish.
module cheshire_commit_watchdog #(
  parameter int NrCommitPorts  = 2,
  parameter int PcWidth        = 64,
  parameter int MaxStallCycles = 10000,
  parameter int GraceCycles    = 100
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic                             clear_i,
  input  logic [NrCommitPorts-1:0]         commit_ack_i,
  input  logic [NrCommitPorts*PcWidth-1:0] commit_pc_i,
  output logic [1:0]                       state_o,
  output logic                             hang_o,
  output logic [PcWidth-1:0]               hang_pc_o,
  output logic                             debug_req_o,
  output logic                             finish_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMonitor = 2'd1;
  localparam logic [1:0] StHang    = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  localparam int CntW = $clog2(MaxStallCycles + 1);
  localparam int GrcW = (GraceCycles > 0) ? $clog2(GraceCycles + 1) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(MaxStallCycles - 1);
  // With zero grace the grace counter is never consulted; the width is kept at one bit.
  localparam logic [GrcW-1:0] GrcLast = (GraceCycles > 0) ? GrcW'(GraceCycles - 1) : '0;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [GrcW-1:0]    grace_q, grace_d;
  logic [PcWidth-1:0] last_pc_q, last_pc_d;
  logic [PcWidth-1:0] hang_pc_q, hang_pc_d;
  logic               hang_q, debug_q, finish_q;

  logic               ack_any;
  logic [PcWidth-1:0] acked_pc;
  logic               progress;

  // Highest-index acknowledging port wins: it is the youngest commit of the cycle.
  always_comb begin
    acked_pc = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (commit_ack_i[p]) acked_pc = commit_pc_i[p*PcWidth +: PcWidth];
    end
  end

  assign ack_any  = |commit_ack_i;
  assign progress = ack_any && (acked_pc != last_pc_q);

  always_comb begin
    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    grace_d   = grace_q;
    last_pc_d = last_pc_q;
    hang_pc_d = hang_pc_q;
    unique case (state_q)
      StIdle: begin
        if (en_i && ack_any) begin
          state_d   = StMonitor;
          last_pc_d = acked_pc;
          cnt_d     = '0;
        end
      end
      StMonitor: begin
        if (en_i) begin
          if (progress) begin
            last_pc_d = acked_pc;
            cnt_d     = '0;
          end else if (cnt_q == CntLast) begin
            state_d   = StHang;
            hang_pc_d = last_pc_q;
            grace_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHang: begin
        if (GraceCycles == 0 || grace_q == GrcLast) begin
          state_d = StDone;
        end else begin
          grace_d = grace_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Soft clear behaves exactly like reset and overrides any pending transition.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i || clear_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grace_q   <= '0;
      last_pc_q <= '0;
      hang_pc_q <= '0;
      hang_q    <= 1'b0;
      debug_q   <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grace_q   <= grace_d;
      last_pc_q <= last_pc_d;
      hang_pc_q <= hang_pc_d;
      hang_q    <= (state_d == StHang) || (state_d == StDone);
      debug_q   <= (state_d == StHang);
      finish_q  <= (state_d == StDone);
    end
  end

  assign state_o     = state_q;
  assign hang_o      = hang_q;
  assign hang_pc_o   = hang_pc_q;
  assign debug_req_o = debug_q;
  assign finish_o    = finish_q;

endmodule

// File: tb/tb_cheshire_commit_watchdog.sv
// Bench for cheshire_commit_watchdog: two instances (grace 4 and grace 0) share stimulus
// and are compared each cycle against a stall-run / hang-age model plus literal checks.
module tb_cheshire_commit_watchdog;

  localparam int NP   = 2;
  localparam int PW   = 64;
  localparam int MAXS = 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            en_i = 1'b0;
  logic            clear_i = 1'b0;
  logic [NP-1:0]   ack_i = '0;
  logic [NP*PW-1:0] pc_i = '0;

  logic [1:0]    st  [2];
  logic          hng [2];
  logic [PW-1:0] hpc [2];
  logic          dbg [2];
  logic          fin [2];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cheshire_commit_watchdog #(.NrCommitPorts(NP), .PcWidth(PW), .MaxStallCycles(MAXS),
                             .GraceCycles(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
    .commit_ack_i(ack_i), .commit_pc_i(pc_i),
    .state_o(st[0]), .hang_o(hng[0]), .hang_pc_o(hpc[0]),
    .debug_req_o(dbg[0]), .finish_o(fin[0]));

  cheshire_commit_watchdog #(.NrCommitPorts(NP), .PcWidth(PW), .MaxStallCycles(MAXS),
                             .GraceCycles(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
    .commit_ack_i(ack_i), .commit_pc_i(pc_i),
    .state_o(st[1]), .hang_o(hng[1]), .hang_pc_o(hpc[1]),
    .debug_req_o(dbg[1]), .finish_o(fin[1]));

  // Model: armed flag, length of the current stall run, and age since the hang was declared.
  int            grace_of [2] = '{4, 0};
  bit            m_armed  [2];
  int            m_stall  [2];
  int            m_age    [2];
  logic [PW-1:0] m_last   [2];
  logic [PW-1:0] m_hpc    [2];

  function automatic logic [PW-1:0] youngest_pc(input logic [NP-1:0] a,
                                                input logic [NP*PW-1:0] p);
    logic [PW-1:0] r = '0;
    for (int i = 0; i < NP; i++) if (a[i]) r = p[i*PW +: PW];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_i || clear_i) begin
        m_armed[k] <= 1'b0;
        m_stall[k] <= 0;
        m_age[k]   <= -1;
        m_last[k]  <= '0;
        m_hpc[k]   <= '0;
      end else if (m_age[k] >= 0) begin
        if (m_age[k] < 1000) m_age[k] <= m_age[k] + 1;
      end else if (!m_armed[k]) begin
        if (en_i && (|ack_i)) begin
          m_armed[k] <= 1'b1;
          m_last[k]  <= youngest_pc(ack_i, pc_i);
          m_stall[k] <= 0;
        end
      end else if (en_i) begin
        if ((|ack_i) && youngest_pc(ack_i, pc_i) != m_last[k]) begin
          m_last[k]  <= youngest_pc(ack_i, pc_i);
          m_stall[k] <= 0;
        end else if (m_stall[k] + 1 == MAXS) begin
          m_age[k] <= 0;
          m_hpc[k] <= m_last[k];
        end else begin
          m_stall[k] <= m_stall[k] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        automatic int dlen = (grace_of[k] > 0) ? grace_of[k] : 1;
        automatic logic [1:0] es = !m_armed[k] ? 2'd0 : (m_age[k] < 0) ? 2'd1 :
                                   (m_age[k] < dlen) ? 2'd2 : 2'd3;
        check($sformatf("mdl_state[%0d]", k), 64'(st[k]), 64'(es));
        check($sformatf("mdl_hang[%0d]", k), 64'(hng[k]), 64'(m_age[k] >= 0));
        check($sformatf("mdl_hang_pc[%0d]", k), hpc[k], m_hpc[k]);
        check($sformatf("mdl_debug[%0d]", k), 64'(dbg[k]),
              64'(m_age[k] >= 0 && m_age[k] < dlen));
        check($sformatf("mdl_finish[%0d]", k), 64'(fin[k]), 64'(m_age[k] >= dlen));
      end
    end
  end

  task automatic step(input logic r, input logic c, input logic e, input logic [NP-1:0] a,
                      input logic [PW-1:0] p0, input logic [PW-1:0] p1);
    rst_i   = r;
    clear_i = c;
    en_i    = e;
    ack_i   = a;
    pc_i    = {p1, p0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, e, 2'b00, 64'h0, 64'h0);
  endtask

  initial begin
    int n_dbg0, n_dbg1;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom});
      cmp_en = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      check("reset_state", 64'(st[k]), 64'd0);
      check("reset_outs", {hpc[k][60:0], hng[k], dbg[k], fin[k]}, 64'd0);
    end

    // 2: arm at 0x8000_0000, then eight stalled cycles
    step(1'b0, 1'b0, 1'b1, 2'b01, 64'h8000_0000, 64'h0);
    check("arm_state", 64'(st[0]), 64'd1);
    idle_cycles(7, 1'b1);
    check("pre_hang", 64'(hng[0]), 64'd0);
    idle_cycles(1, 1'b1);
    check("hang_rise", 64'(hng[0]), 64'd1);
    check("hang_pc", hpc[0], 64'h8000_0000);
    check("hang_pc_g0", hpc[1], 64'h8000_0000);
    n_dbg0 = int'(dbg[0]);
    n_dbg1 = int'(dbg[1]);
    for (int i = 0; i < 10; i++) begin
      idle_cycles(1, 1'b1);
      n_dbg0 += int'(dbg[0]);
      n_dbg1 += int'(dbg[1]);
    end
    check("debug_len", 64'(n_dbg0), 64'd4);
    check("debug_len_g0", 64'(n_dbg1), 64'd1);
    check("finish_sticky", {62'd0, fin[0], fin[1]}, 64'd3);
    check("done_state", 64'(st[0]), 64'd3);

    // 3: en_i low ignores acks in IDLE; then progress every 7th cycle never hangs
    step(1'b0, 1'b1, 1'b1, 2'b00, 64'h0, 64'h0);
    check("clear_done", 64'(st[0]), 64'd0);
    step(1'b0, 1'b0, 1'b0, 2'b01, 64'h1000, 64'h0);
    check("idle_en_low", 64'(st[0]), 64'd0);
    for (int i = 0; i < 200; i++) begin
      if (i % 7 == 0) step(1'b0, 1'b0, 1'b1, 2'b01, 64'h1000 + 64'(4 * (i / 7)), 64'h0);
      else idle_cycles(1, 1'b1);
    end
    check("progress_nohang", {62'd0, hng[0], hng[1]}, 64'd0);
    check("progress_state", 64'(st[0]), 64'd1);

    // 4: self-loop on port 1 while port 0 also acks
    step(1'b0, 1'b1, 1'b1, 2'b00, 64'h0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 2'b11, 64'h1FFC, 64'h2000);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 2'b11, 64'h1FFC, 64'h2000);
    check("selfloop_pre", 64'(hng[0]), 64'd0);
    step(1'b0, 1'b0, 1'b1, 2'b11, 64'h1FFC, 64'h2000);
    check("selfloop_hang", 64'(hng[0]), 64'd1);
    check("selfloop_pc", hpc[0], 64'h2000);

    // 5: pause with en_i low (acks ignored), resume, then clear in HANG
    step(1'b0, 1'b1, 1'b1, 2'b00, 64'h0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 64'h3000, 64'h0);
    idle_cycles(5, 1'b1);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 1'b0, (i % 4 == 0) ? 2'b01 : 2'b00, 64'h4000, 64'h0);
    check("pause_state", 64'(st[0]), 64'd1);
    idle_cycles(2, 1'b1);
    check("resume_pre", 64'(hng[0]), 64'd0);
    idle_cycles(1, 1'b1);
    check("resume_hang", 64'(hng[0]), 64'd1);
    check("resume_pc", hpc[0], 64'h3000);
    step(1'b0, 1'b1, 1'b1, 2'b00, 64'h0, 64'h0);
    check("clear_hang", {60'd0, st[0], dbg[0], fin[0]}, 64'd0);

    // mid-operation reset aborts MONITOR
    step(1'b0, 1'b0, 1'b1, 2'b10, 64'h0, 64'h5000);
    idle_cycles(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 64'h0, 64'h0);
    check("reset_mid", 64'(st[0]), 64'd0);
    idle_cycles(3, 1'b1);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
